// File: rtl/enigma_pkg.sv
// Shared Enigma definitions: letter/position widths, rotor codes, inverse wirings, mod-26 helpers.
package enigma_pkg;

  localparam int unsigned LETTER_COUNT = 26;
  localparam int unsigned LETTER_W     = 5;
  localparam int unsigned POS_W        = 7;

  typedef enum logic [1:0] {
    ROTOR_I   = 2'd0,
    ROTOR_II  = 2'd1,
    ROTOR_III = 2'd2
  } rotor_type_e;

  typedef logic [LETTER_W-1:0] letter_t;
  typedef logic [POS_W-1:0]    pos_t;

  // Payload carried between stages; positions for later stages ride with the letter.
  typedef struct packed {
    logic    err;
    letter_t letter;
    pos_t    pos_mid;
    pos_t    pos_right;
  } stage_data_t;

  // Inverse wirings, index = contact entering from the left, value = contact leaving on the right.
  localparam letter_t INV_I [LETTER_COUNT] = '{
    5'd20, 5'd22, 5'd24, 5'd6,  5'd0,  5'd3,  5'd5,  5'd15, 5'd21, 5'd25, 5'd1,  5'd4,  5'd2,
    5'd10, 5'd12, 5'd19, 5'd7,  5'd23, 5'd18, 5'd11, 5'd17, 5'd8,  5'd13, 5'd16, 5'd14, 5'd9
  };
  localparam letter_t INV_II [LETTER_COUNT] = '{
    5'd0,  5'd9,  5'd15, 5'd2,  5'd25, 5'd22, 5'd17, 5'd11, 5'd5,  5'd1,  5'd3,  5'd10, 5'd14,
    5'd19, 5'd24, 5'd20, 5'd16, 5'd6,  5'd4,  5'd13, 5'd7,  5'd23, 5'd12, 5'd8,  5'd21, 5'd18
  };
  localparam letter_t INV_III [LETTER_COUNT] = '{
    5'd19, 5'd0,  5'd6,  5'd1,  5'd15, 5'd2,  5'd18, 5'd3,  5'd16, 5'd4,  5'd20, 5'd5,  5'd21,
    5'd13, 5'd25, 5'd7,  5'd24, 5'd8,  5'd23, 5'd9,  5'd22, 5'd11, 5'd17, 5'd10, 5'd14, 5'd12
  };

  function automatic letter_t inv_wiring(rotor_type_e t, letter_t idx);
    letter_t w;
    w = '0;
    case (t)
      ROTOR_II:  w = INV_II[idx];
      ROTOR_III: w = INV_III[idx];
      default:   w = INV_I[idx];
    endcase
    return w;
  endfunction

  // Operands are expected in 0..25.
  function automatic pos_t mod26_add(pos_t a, pos_t b);
    pos_t s;
    s = a + b;
    if (s >= pos_t'(LETTER_COUNT)) s = s - pos_t'(LETTER_COUNT);
    return s;
  endfunction

  function automatic pos_t mod26_sub(pos_t a, pos_t b);
    pos_t s;
    s = a + pos_t'(LETTER_COUNT) - b;
    if (s >= pos_t'(LETTER_COUNT)) s = s - pos_t'(LETTER_COUNT);
    return s;
  endfunction

endpackage

// File: rtl/rotor_return_path_if.sv
// Reflector-side input and lampboard-side output handshake bundle.
interface rotor_return_path_if;
  import enigma_pkg::*;

  logic    in_valid;
  logic    in_ready;
  letter_t in_letter;
  pos_t    pos_left;
  pos_t    pos_mid;
  pos_t    pos_right;
  logic    out_valid;
  logic    out_ready;
  letter_t out_letter;
  logic    out_err;

  modport master (
    output in_valid, in_letter, pos_left, pos_mid, pos_right, out_ready,
    input  in_ready, out_valid, out_letter, out_err
  );

  modport slave (
    input  in_valid, in_letter, pos_left, pos_mid, pos_right, out_ready,
    output in_ready, out_valid, out_letter, out_err
  );
endinterface

// File: rtl/rotor_inverse_stage.sv
// One rotor passed in reverse: offset, inverse wiring, un-offset, then a valid/ready register slice.
module rotor_inverse_stage
  import enigma_pkg::*;
#(
  parameter int unsigned TYPE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  pos_t        in_pos,
  input  stage_data_t in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output stage_data_t out_data
);

  localparam rotor_type_e RTYPE = rotor_type_e'(2'(TYPE));

  stage_data_t nxt_c;
  pos_t        sum_c;
  letter_t     wired_c;

  // Letter transform through this rotor; all other payload fields pass unchanged.
  always_comb begin
    nxt_c        = in_data;
    sum_c        = mod26_add(pos_t'(in_data.letter), in_pos);
    wired_c      = inv_wiring(RTYPE, letter_t'(sum_c));
    nxt_c.letter = letter_t'(mod26_sub(pos_t'(wired_c), in_pos));
  end

  assign in_ready = !out_valid || out_ready;

  // Register slice: load when empty or draining, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= nxt_c;
    end
  end

endmodule

// File: rtl/rotor_return_path.sv
// Reverse path through the rotor stack: left, middle, right, as a 3-deep valid/ready pipeline.
module rotor_return_path
  import enigma_pkg::*;
#(
  parameter int unsigned LEFT_TYPE  = 0,
  parameter int unsigned MID_TYPE   = 1,
  parameter int unsigned RIGHT_TYPE = 2
) (
  input logic                clk,
  input logic                reset,
  rotor_return_path_if.slave bus
);

  logic        letter_ok_c, left_ok_c, mid_ok_c, right_ok_c;
  stage_data_t s0_data_c;
  pos_t        s0_pos_c;

  logic        rdy1, rdy2, rdy3;
  logic        v1, v2, v3;
  stage_data_t s1_data, s2_data, s3_data;
  logic        unused_s3_pos;

  assign letter_ok_c = bus.in_letter < letter_t'(LETTER_COUNT);
  assign left_ok_c   = bus.pos_left  < pos_t'(LETTER_COUNT);
  assign mid_ok_c    = bus.pos_mid   < pos_t'(LETTER_COUNT);
  assign right_ok_c  = bus.pos_right < pos_t'(LETTER_COUNT);

  // Sanitize inputs: out-of-range values become 0 and flag the letter.
  always_comb begin
    s0_data_c           = '0;
    s0_pos_c            = '0;
    s0_data_c.letter    = letter_ok_c ? bus.in_letter : '0;
    s0_data_c.pos_mid   = mid_ok_c    ? bus.pos_mid   : '0;
    s0_data_c.pos_right = right_ok_c  ? bus.pos_right : '0;
    s0_data_c.err       = !(letter_ok_c && left_ok_c && mid_ok_c && right_ok_c);
    s0_pos_c            = left_ok_c   ? bus.pos_left  : '0;
  end

  rotor_inverse_stage #(.TYPE(LEFT_TYPE)) u_left (
    .clk(clk), .reset(reset),
    .in_valid(bus.in_valid), .in_ready(rdy1), .in_pos(s0_pos_c), .in_data(s0_data_c),
    .out_valid(v1), .out_ready(rdy2), .out_data(s1_data)
  );

  rotor_inverse_stage #(.TYPE(MID_TYPE)) u_mid (
    .clk(clk), .reset(reset),
    .in_valid(v1), .in_ready(rdy2), .in_pos(s1_data.pos_mid), .in_data(s1_data),
    .out_valid(v2), .out_ready(rdy3), .out_data(s2_data)
  );

  rotor_inverse_stage #(.TYPE(RIGHT_TYPE)) u_right (
    .clk(clk), .reset(reset),
    .in_valid(v2), .in_ready(rdy3), .in_pos(s2_data.pos_right), .in_data(s2_data),
    .out_valid(v3), .out_ready(bus.out_ready), .out_data(s3_data)
  );

  assign bus.in_ready   = rdy1;
  assign bus.out_valid  = v3;
  assign bus.out_letter = s3_data.letter;
  assign bus.out_err    = s3_data.err;

  // Positions are fully consumed by the last stage.
  assign unused_s3_pos = ^{s3_data.pos_mid, s3_data.pos_right};

endmodule

// File: tb/tb_rotor_return_path.sv
// Directed plus random stimulus against a string-table reference model and an in-order scoreboard.
module tb_rotor_return_path;

  typedef struct {
    int letter;
    int err;
  } exp_t;

  logic  clk;
  logic  reset;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    n_accept = 0;
  int    n_pop    = 0;
  exp_t  exp_q[$];
  string inv_tab[3];
  logic  hold_pending = 1'b0;
  logic [4:0] hold_letter = '0;
  logic  hold_err = 1'b0;

  rotor_return_path_if bus ();

  rotor_return_path #(.LEFT_TYPE(0), .MID_TYPE(1), .RIGHT_TYPE(2)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rotor order left/mid/right uses wirings I/II/III, i.e. table index k.
  function automatic exp_t model(int l, int pl, int pm, int pr);
    exp_t r;
    int   p[3];
    int   c;
    r.err = 0;
    if (l  > 25) begin l  = 0; r.err = 1; end
    if (pl > 25) begin pl = 0; r.err = 1; end
    if (pm > 25) begin pm = 0; r.err = 1; end
    if (pr > 25) begin pr = 0; r.err = 1; end
    p[0] = pl; p[1] = pm; p[2] = pr;
    c = l;
    for (int k = 0; k < 3; k++) begin
      int s;
      int w;
      s = (c + p[k]) % 26;
      w = int'(inv_tab[k][s]) - 65;
      c = (w - p[k] + 26) % 26;
    end
    r.letter = c;
    return r;
  endfunction

  // One clock: drive at negedge, settle, then score what the coming posedge will transfer.
  task automatic cycle(input logic rst, input logic iv, input logic [4:0] l,
                       input logic [6:0] pl, input logic [6:0] pm, input logic [6:0] pr,
                       input logic ordy);
    exp_t e;
    @(negedge clk);
    reset         = rst;
    bus.in_valid  = iv;
    bus.in_letter = l;
    bus.pos_left  = pl;
    bus.pos_mid   = pm;
    bus.pos_right = pr;
    bus.out_ready = ordy;
    #1;
    if (rst) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_letter", bus.out_letter, hold_letter);
        check("hold_err", bus.out_err, hold_err);
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", bus.out_valid, 0);
        end else begin
          check("sb_letter", bus.out_letter, exp_q[0].letter);
          check("sb_err", bus.out_err, exp_q[0].err);
          if (ordy) begin
            void'(exp_q.pop_front());
            n_pop++;
          end
        end
      end
      hold_pending = bus.out_valid && !ordy;
      hold_letter  = bus.out_letter;
      hold_err     = bus.out_err;
      if (iv && bus.in_ready) begin
        e = model(int'(l), int'(pl), int'(pm), int'(pr));
        exp_q.push_back(e);
        n_accept++;
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, 1'b0, 5'd0, 7'd0, 7'd0, 7'd0, ordy);
  endtask

  // Single letter through an empty pipe: valid must rise exactly on the third edge.
  task automatic run_one(input string tag, input logic [4:0] l, input logic [6:0] pl,
                         input logic [6:0] pm, input logic [6:0] pr,
                         input int exp_letter, input int exp_err);
    cycle(1'b0, 1'b1, l, pl, pm, pr, 1'b1);
    idle(1'b1);
    check({tag, "_lat1"}, bus.out_valid, 0);
    idle(1'b1);
    check({tag, "_lat2"}, bus.out_valid, 0);
    idle(1'b1);
    check({tag, "_valid"}, bus.out_valid, 1);
    check({tag, "_letter"}, bus.out_letter, exp_letter);
    check({tag, "_err"}, bus.out_err, exp_err);
  endtask

  initial begin
    int acc0;
    int pop0;
    inv_tab[0] = "UWYGADFPVZBECKMTHXSLRINQOJ";
    inv_tab[1] = "AJPCZWRLFBDKOTYUQGENHXMIVS";
    inv_tab[2] = "TAGBPCSDQEUFVNZHYIXJWLRKOM";
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_letter = '0; bus.out_ready = 1'b0;
    bus.pos_left = '0; bus.pos_mid = '0; bus.pos_right = '0;

    cycle(1'b1, 1'b0, 5'd0, 7'd0, 7'd0, 7'd0, 1'b0);
    idle(1'b0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_letter", bus.out_letter, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_in_ready", bus.in_ready, 1);

    run_one("base",      5'd0,  7'd0,  7'd0,   7'd0, 3,  0);
    run_one("right1",    5'd0,  7'd0,  7'd0,   7'd1, 15, 0);
    run_one("left25",    5'd0,  7'd25, 7'd0,   7'd0, 1,  0);
    run_one("bad_let",   5'd30, 7'd0,  7'd0,   7'd0, 3,  1);
    run_one("after_bad", 5'd0,  7'd0,  7'd0,   7'd0, 3,  0);
    run_one("bad_pos",   5'd0,  7'd0,  7'd100, 7'd0, 3,  1);

    // Stall: downstream blocked for 5 cycles while letters keep coming.
    acc0 = n_accept;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b1, 5'd0, 7'd0, 7'd0, 7'd0, 1'b0);
      check("stall_in_ready", bus.in_ready, (i < 3) ? 1 : 0);
    end
    check("stall_accepts", n_accept - acc0, 3);
    check("stall_letter", bus.out_letter, 3);
    pop0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check("release_valid", bus.out_valid, (i < 3) ? 1 : 0);
    end
    check("release_pops", n_pop - pop0, 3);
    check("release_empty", exp_q.size(), 0);

    // Reset with two letters in flight.
    cycle(1'b0, 1'b1, 5'd7, 7'd3, 7'd4, 7'd5, 1'b1);
    cycle(1'b0, 1'b1, 5'd9, 7'd1, 7'd2, 7'd3, 1'b1);
    cycle(1'b1, 1'b1, 5'd4, 7'd0, 7'd0, 7'd0, 1'b0);
    idle(1'b1);
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_letter", bus.out_letter, 0);
    check("midrst_err", bus.out_err, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    repeat (5) idle(1'b1);

    // Random traffic with random backpressure and occasional out-of-range values.
    for (int i = 0; i < 400; i++) begin
      logic [6:0] p[3];
      for (int k = 0; k < 3; k++)
        p[k] = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(26, 127)) : 7'($urandom_range(0, 25));
      cycle(1'b0, 1'($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31)),
            p[0], p[1], p[2], 1'($urandom_range(0, 9) < 7));
    end
    repeat (20) idle(1'b1);
    check("drain_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rotor_return_path.md
Name: rotor_return_path

Overview:
- Reverse-direction letter encoder for a three-rotor Enigma stack.
- Takes the letter coming back from the reflector and passes it through the rotors in reverse order: left, then middle, then right.
- Each rotor stage uses that rotor's inverse wiring, offset by the rotor position supplied by the rotor counters.
- Structure: 3-stage valid/ready pipeline, sitting between the reflector and the lampboard output.

Parameters:
- LEFT_TYPE, default 0: wiring of left rotor (0=I, 1=II, 2=III).
- MID_TYPE, default 1: wiring of middle rotor (same encoding).
- RIGHT_TYPE, default 2: wiring of right rotor (same encoding).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  in_letter and positions are valid this cycle.
- in_ready  output  1  block accepts the input this cycle.
- in_letter  input  5  letter from reflector, 0..25.
- pos_left  input  7  left rotor position, 0..25, 7-bit as driven by rotor counters.
- pos_mid  input  7  middle rotor position.
- pos_right  input  7  right rotor position.
- out_valid  output  1  out_letter is valid.
- out_ready  input  1  downstream accepts output.
- out_letter  output  5  encoded letter, 0..25.
- out_err  output  1  an out-of-range input or position was seen for this letter.

Behaviour:
- Reset: all stage valid bits 0, all stage data 0, so out_valid=0, out_letter=0, out_err=0. in_ready=1 in the cycle after reset deasserts. Reset mid-flight discards all in-flight letters.
- Accept rule: a transfer occurs when in_valid && in_ready. At accept, stage 1 captures in_letter, pos_mid and pos_right. Captured positions travel with the letter, so rotor stepping after accept never affects that letter.
- Stage k transform, with c = letter in and p = position:
  - s = (c + p) mod 26
  - w = INV[type][s]
  - out = (w - p + 26) mod 26
  - All arithmetic is done at 7 bits; the result is truncated to 5 bits.
- Stage order:
  - Stage 1 = left, computed from the input registers at accept and registered.
  - Stage 2 = mid.
  - Stage 3 = right; stage 3 is the output register.
- Latency: a letter accepted at edge N appears with out_valid=1 after edge N+2 (three registered stages), given no stall.
- Handshake:
  - Each stage holds its data while valid && !ready_downstream.
  - ready_k = !valid_k || ready_(k+1); in_ready = ready_1; stage 3 ready = out_ready.
  - Throughput is one letter per cycle when out_ready=1.
  - out_letter and out_err are stable while out_valid && !out_ready.
- Out-of-range inputs: if in_letter > 25 or any pos > 25 at accept, that value is replaced by 0 and err is set. err propagates with the letter to out_err. No other effect; the pipeline keeps flowing.
- Simultaneous events: accept into stage 1 and drain from stage 3 in the same cycle is legal. reset dominates in_valid.

Decomposition:
- Shared package enigma_pkg:
  - LETTER_COUNT=26; rotor type codes ROTOR_I/II/III.
  - Inverse wiring tables, as 26-entry 5-bit arrays:
    - I inv = UWYGADFPVZBECKMTHXSLRINQOJ
    - II inv = AJPCZWRLFBDKOTYUQGENHXMIVS
    - III inv = TAGBPCSDQEUFVNZHYIXJWLRKOM
  - A mod-26 add/subtract function.
- Sub-module rotor_inverse_stage:
  - Parameter TYPE; combinational transform plus one valid/ready register slice.
  - Instantiated three times.

Test Plan:
- Positions 0,0,0 with rotor types I/II/III; in_letter=0 -> out_letter=3, out_err=0, out_valid rises 3 edges after accept.
- pos_right=1, others 0; in_letter=0 -> out_letter=15.
- pos_left=25, others 0; in_letter=0 -> out_letter=1 (wrap in both add and subtract).
- in_letter=30 with positions 0 -> treated as 0, out_letter=3, out_err=1; next letter 0 -> out_err=0.
- Back-to-back letters 0,0,0 with out_ready held 0 for 5 cycles -> in_ready falls after 3 accepts, out_letter held at 3; release -> three outputs on consecutive cycles, no loss or duplication.
- Assert reset with 2 letters in flight -> next cycle out_valid=0, out_letter=0; no stale letter emitted afterwards.
